// File: rtl/clk_gating_pkg.sv
// clk_gating_pkg: shared constants for the clock gate
package clk_gating_pkg;
   localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/clk_gating_cell.sv
// clk_gating_cell: latch-plus-AND clock gate, replaceable by a library ICG cell
module clk_gating_cell (
   input  logic clk,
   input  logic en,
   output logic clk_g,
   output logic en_l
);
   always_latch if (!clk) en_l = en;
   assign clk_g = clk & en_l;
endmodule

// File: rtl/clk_gating.sv
// clk_gating: glitch-free clock gate with reset handling, test override and pulse counter
module clk_gating
   import clk_gating_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter bit RST_OPEN = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             test_en_i,
   output logic             clk_o,
   output logic             gate_open_o,
   output logic [CNT_W-1:0] pulse_cnt_o
);
   logic rst_q;
   logic en_eff;
   logic en_l;
   always_ff @(posedge clk_i) rst_q <= rst_ni;
   assign en_eff = rst_q ? (en_i | test_en_i) : RST_OPEN;
   (* dont_touch = "true" *)
   clk_gating_cell u_cell (
      .clk   (clk_i),
      .en    (en_eff),
      .clk_g (clk_o),
      .en_l  (en_l)
   );
   assign gate_open_o = en_l;
   // en_l is stable across the rising edge, so it reflects the pulse being passed
   always_ff @(posedge clk_i) begin
      if (!rst_ni) pulse_cnt_o <= '0;
      else if (en_l && rst_q && pulse_cnt_o != '1) pulse_cnt_o <= pulse_cnt_o + CNT_W'(1);
   end
endmodule

// File: tb/tb_clk_gating.sv
// tb_clk_gating: directed scoreboard bench for the clock gate
`timescale 1ns/1ps
module tb_clk_gating;
   logic        clk_i, rst_ni, en_i, test_en_i, en2;
   logic        clk_o, gate_open_o, clk_o2, gate_open_o2;
   logic [15:0] pulse_cnt_o;
   logic [1:0]  sat_cnt;
   int          n_tests = 0, n_fail = 0;
   int          rises = 0, base = 0, bad_low = 0;

   typedef struct {
      string       tag;
      int          sig;
      logic [15:0] exp;
   } item_t;
   item_t q[$];

   clk_gating #(.CNT_W(16), .RST_OPEN(1'b0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .test_en_i(test_en_i),
      .clk_o(clk_o), .gate_open_o(gate_open_o), .pulse_cnt_o(pulse_cnt_o)
   );

   clk_gating #(.CNT_W(2), .RST_OPEN(1'b0)) dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en2), .test_en_i(1'b0),
      .clk_o(clk_o2), .gate_open_o(gate_open_o2), .pulse_cnt_o(sat_cnt)
   );

   // low 0-10, rising edges at 10, 20, 30 ...
   initial begin
      clk_i = 1'b0;
      #5;
      forever begin
         #5 clk_i = 1'b1;
         #5 clk_i = 1'b0;
      end
   end

   always @(posedge clk_o) rises++;
   always @(negedge clk_i) begin
      #1;
      if (clk_o === 1'b1) bad_low++;
   end

   function automatic logic [15:0] observe(input int sig);
      case (sig)
         0:       return {15'd0, clk_o};
         1:       return {15'd0, gate_open_o};
         2:       return pulse_cnt_o;
         3:       return {14'd0, sat_cnt};
         4:       return 16'(rises - base);
         default: return 16'(bad_low);
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [15:0] exp);
      item_t it;
      it.tag = tag;
      it.sig = sig;
      it.exp = exp;
      q.push_back(it);
   endtask

   task automatic drain();
      item_t       it;
      logic [15:0] obs;
      while (q.size() > 0) begin
         it  = q.pop_front();
         obs = observe(it.sig);
         n_tests++;
         assert (obs === it.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic at(input int t);
      #(t - int'($time));
   endtask

   initial begin
      rst_ni = 1'b0; en_i = 1'b0; test_en_i = 1'b0; en2 = 1'b0;
      at(12); rst_ni = 1'b1;
      at(16);
      push("rst_clk_o", 0, 0); push("rst_gate", 1, 0); push("rst_cnt", 2, 0); push("rst_sat", 3, 0);
      drain();
      // enable rises while clk_i low
      at(27); push("t1_gate_before", 1, 0); drain(); base = rises;
      at(28); en_i = 1'b1;
      at(29); push("t1_gate_after", 1, 1); push("t1_clk_low", 0, 0); drain();
      at(31); push("t1_clk_high", 0, 1); push("t1_cnt", 2, 1); drain();
      at(36); push("t1_clk_fall", 0, 0); drain();
      // enable falls while clk_i low
      at(37); en_i = 1'b0;
      at(38); push("t2_gate", 1, 0); drain();
      at(41); push("t2_clk_supp", 0, 0); push("t2_cnt_hold", 2, 1); drain();
      // enable pulse during high phase must not leak
      en_i = 1'b1;
      at(42); push("t3_gate_hold", 1, 0); push("t3_clk", 0, 0); drain();
      at(44); en_i = 1'b0;
      at(46); push("t3_no_glitch", 4, 1); push("t3_gate", 1, 0); drain();
      // test override wins, en_i don't-care
      test_en_i = 1'b1; en_i = 1'bx;
      at(47); push("t4_gate", 1, 1); drain();
      at(51); push("t4_clk", 0, 1); push("t4_cnt", 2, 2); drain();
      at(56); en_i = 1'b1;
      at(57); test_en_i = 1'b0;
      at(61); push("t4_cnt2", 2, 3); push("t4_clk2", 0, 1); drain();
      // reset mid-stream
      at(62); rst_ni = 1'b0;
      at(66); push("t5_gate_pre", 1, 1); drain();
      at(71); push("t5_pulse_passed", 0, 1); push("t5_cnt_clr", 2, 0); drain();
      at(76); push("t5_gate_closed", 1, 0); drain();
      at(81); push("t5_clk_low80", 0, 0); drain();
      at(91); push("t5_clk_low90", 0, 0); drain();
      at(92); rst_ni = 1'b1;
      at(101); push("t5_clk_low100", 0, 0); push("t5_cnt100", 2, 0); drain();
      at(106); push("t5_gate_reopen", 1, 1); drain();
      at(111); push("t5_clk_resume", 0, 1); push("t5_cnt_resume", 2, 1); drain();
      // saturation with a 2-bit counter
      at(116); en2 = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         at(111 + 10 * n);
         push($sformatf("t6_sat_%0d", n), 3, 16'(n > 3 ? 3 : n));
         if (n == 1) push("t6_main_cnt", 2, 2);
         drain();
      end
      at(176); en2 = 1'b0;
      at(181); push("t6_sat_hold", 3, 3); drain();
      push("never_high_low", 5, 0); drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
